plot_arbiter: RTL
=================

PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 Parameter: MAX_BURST, 16, maximum pixels accepted per grant before forced release (legal range 1..255).
REQ-002 Parameter: X_MAX, 320, screen width; pixels with x >= X_MAX are out of range.
REQ-003 Parameter: Y_MAX, 240, screen height; pixels with y >= Y_MAX are out of range.
REQ-004 Port: clock  in  1  single system clock (CLOCK_50); all state changes on its rising edge.
REQ-005 Port: resetn  in  1  asynchronous, active-low reset.
REQ-006 Port: req  in  3  per-requester request; bit i belongs to requester i.
REQ-007 Port: px  in  27  packed x coordinates, requester i at bits [9i+8:9i].
REQ-008 Port: py  in  24  packed y coordinates, requester i at bits [8i+7:8i].
REQ-009 Port: pcol  in  9  packed colours, requester i at bits [3i+2:3i].
REQ-010 Port: pvalid  in  3  per-requester pixel-valid strobe.
REQ-011 Port: plast  in  3  per-requester last-pixel-of-sprite flag, qualified by pvalid.
REQ-012 Port: gnt  out  3  registered one-hot grant; all zero when idle.
REQ-013 Port: vga_x  out  9  registered x to VGA adapter.
REQ-014 Port: vga_y  out  8  registered y to VGA adapter.
REQ-015 Port: vga_colour  out  3  registered colour to VGA adapter.
REQ-016 Port: vga_plot  out  1  registered write enable to VGA adapter.
REQ-017 Port: dropped  out  1  one-cycle pulse when an accepted pixel is suppressed as out of range.
REQ-018 Port: busy  out  1  high while in GRANT state.

Function
REQ-019 FSM states: IDLE, GRANT; the grant index register g (0..2) is meaningful only in GRANT.
REQ-020 IDLE: if any req bit is high, select g round-robin, searching upward from (last_served+1) mod 3 with wrap; enter GRANT; gnt = one-hot(g) from the next cycle.
REQ-021 IDLE with req = 0: remain in IDLE with gnt = 0.
REQ-022 GRANT: a pixel is accepted in a cycle when pvalid[g] = 1; pvalid from non-granted requesters is ignored and never plotted.
REQ-023 Accepted in-range pixel: vga_x/vga_y/vga_colour = px/py/pcol slice g, and vga_plot = 1, exactly one cycle after acceptance (latency 1).
REQ-024 Accepted out-of-range pixel (x >= X_MAX or y >= Y_MAX): vga_plot = 0, dropped = 1 one cycle after acceptance; the pixel still counts toward the burst.
REQ-025 vga_plot = 0 in every cycle that does not follow an acceptance; vga_x/vga_y/vga_colour hold their last values.
REQ-026 8-bit burst counter: cleared on entry to GRANT, incremented per accepted pixel.
REQ-027 Release conditions, any of: accepted pixel with plast[g] = 1; accepted pixel that is the MAX_BURST-th of the grant; req[g] = 0 sampled in GRANT.
REQ-028 On release: return to IDLE, gnt = 0 on the next cycle, last_served = g; at least one IDLE cycle separates consecutive grants.
REQ-029 Release caused by req[g] dropping in the same cycle as pvalid[g]: that pixel is still accepted and plotted.
REQ-030 Forced release by MAX_BURST: the next grant goes to the next requester round-robin even if req[g] is still high.
REQ-031 Round-robin order: a continuously requesting requester waits at most two grants.

Reset
REQ-032 While resetn = 0: state = IDLE, gnt = 0, vga_plot = 0, dropped = 0, busy = 0, vga_x = 0, vga_y = 0, vga_colour = 0, burst counter = 0, last_served = 2 (first search starts at requester 0).
REQ-033 Reset asserted mid-grant: abort immediately (asynchronous); no further vga_plot pulse for any pixel accepted in that cycle.

Verification
REQ-034 req = 3'b111 held, 16 pixels each with plast on the 16th -> grants in order 0, 1, 2, 0; 16 vga_plot pulses per grant; one idle gap between grants.
REQ-035 Requester 1 granted, 20 pixels, no plast, MAX_BURST = 16 -> 16 plots, then gnt = 0, then gnt = 3'b100 if req[2] = 1, otherwise gnt = 3'b010 again.
REQ-036 Requester 0 sends x = 319, y = 239, then x = 320, y = 10 -> first pixel plotted at (319,239); second pixel gives vga_plot = 0 and dropped = 1.
REQ-037 pvalid[2] = 1 while gnt = 3'b001 -> no plot of requester 2 data; requester 0 pixels plot with 1-cycle latency.
REQ-038 resetn pulsed low during the 5th pixel of a grant -> all outputs 0 within the reset; after release, req = 3'b010 yields gnt = 3'b010.

Source files
------------

// File: rtl/plot_arbiter_if.sv
// rtl/plot_arbiter_if.sv - requester-side pixel bus and VGA-side outputs of the plot arbiter
// The arbiter connects through the slave modport; the requesters/adapter use master.
interface plot_arbiter_if;
  logic [2:0]  req;
  logic [26:0] px;
  logic [23:0] py;
  logic [8:0]  pcol;
  logic [2:0]  pvalid;
  logic [2:0]  plast;
  logic [2:0]  gnt;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        dropped;
  logic        busy;

  modport slave (
    input  req, px, py, pcol, pvalid, plast,
    output gnt, vga_x, vga_y, vga_colour, vga_plot, dropped, busy
  );

  modport master (
    output req, px, py, pcol, pvalid, plast,
    input  gnt, vga_x, vga_y, vga_colour, vga_plot, dropped, busy
  );
endinterface

// File: rtl/plot_arbiter.sv
// rtl/plot_arbiter.sv - round-robin arbiter of three pixel plotters onto one VGA adapter port
// Bursts end on plast, on the MAX_BURST-th pixel, or when the owner drops its request.
module plot_arbiter #(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned X_MAX     = 320,
  parameter int unsigned Y_MAX     = 240
) (
  input logic          clock,
  input logic          resetn,
  plot_arbiter_if.slave bus
);

  localparam logic [9:0] X_LIM     = 10'(X_MAX);
  localparam logic [8:0] Y_LIM     = 9'(Y_MAX);
  localparam logic [8:0] BURST_LIM = 9'(MAX_BURST);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] g_q, g_d;
  logic [1:0] last_q, last_d;
  logic [7:0] burst_q, burst_d;
  logic [2:0] gnt_q, gnt_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [2:0] c_q, c_d;
  logic       plot_q, plot_d;
  logic       drop_q, drop_d;

  logic [8:0] sel_x;
  logic [7:0] sel_y;
  logic [2:0] sel_c;
  logic       sel_valid, sel_last, sel_req;
  logic [1:0] first, second, third, pick;
  logic       in_range, burst_hit;

  // Mux the currently granted requester's lanes; g_q is never 3.
  always_comb begin
    sel_x     = bus.px[8:0];
    sel_y     = bus.py[7:0];
    sel_c     = bus.pcol[2:0];
    sel_valid = bus.pvalid[0];
    sel_last  = bus.plast[0];
    sel_req   = bus.req[0];
    case (g_q)
      2'd1: begin
        sel_x     = bus.px[17:9];
        sel_y     = bus.py[15:8];
        sel_c     = bus.pcol[5:3];
        sel_valid = bus.pvalid[1];
        sel_last  = bus.plast[1];
        sel_req   = bus.req[1];
      end
      2'd2: begin
        sel_x     = bus.px[26:18];
        sel_y     = bus.py[23:16];
        sel_c     = bus.pcol[8:6];
        sel_valid = bus.pvalid[2];
        sel_last  = bus.plast[2];
        sel_req   = bus.req[2];
      end
      default: ;
    endcase
  end

  always_comb begin
    first  = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    second = (first  == 2'd2) ? 2'd0 : first  + 2'd1;
    third  = (second == 2'd2) ? 2'd0 : second + 2'd1;
    if (bus.req[first])       pick = first;
    else if (bus.req[second]) pick = second;
    else                      pick = third;
  end

  assign in_range  = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
  assign burst_hit = ({1'b0, burst_q} + 9'd1) == BURST_LIM;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    burst_d = burst_q;
    gnt_d   = 3'b000;
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    plot_d  = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          g_d     = pick;
          burst_d = 8'd0;
          gnt_d   = 3'b001 << pick;
        end
      end
      GRANT: begin
        gnt_d = gnt_q;
        if (sel_valid) begin
          burst_d = burst_q + 8'd1;
          if (in_range) begin
            plot_d = 1'b1;
            x_d    = sel_x;
            y_d    = sel_y;
            c_d    = sel_c;
          end else begin
            drop_d = 1'b1;
          end
        end
        // A pixel arriving with the request drop is still plotted above.
        if ((sel_valid && (sel_last || burst_hit)) || !sel_req) begin
          state_d = IDLE;
          last_d  = g_q;
          gnt_d   = 3'b000;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      g_q     <= 2'd0;
      last_q  <= 2'd2;
      burst_q <= 8'd0;
      gnt_q   <= 3'b000;
      x_q     <= 9'd0;
      y_q     <= 8'd0;
      c_q     <= 3'd0;
      plot_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      gnt_q   <= gnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      plot_q  <= plot_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.vga_x      = x_q;
  assign bus.vga_y      = y_q;
  assign bus.vga_colour = c_q;
  assign bus.vga_plot   = plot_q;
  assign bus.dropped    = drop_q;
  assign bus.busy       = (state_q == GRANT);

endmodule
